// File: rtl/dmem_responder.sv
// Fixed-latency 64-bit data memory responder with a valid/ready request/response handshake.
// A request is accepted in IDLE and committed LATENCY edges later. The response is held until resp_ready.
module dmem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_error
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  count;
   logic        cap_write;
   logic [63:0] cap_addr;
   logic [63:0] cap_wdata;

   logic [63:0] memory [DEPTH];

   logic             commit;
   logic             c_write;
   logic             c_err;
   logic [63:0]      c_addr;
   logic [63:0]      c_wdata;
   logic [IDX_W-1:0] c_idx;

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (count == 4'd0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // With LATENCY = 1 the commit happens on the accept edge itself, so the live request is used.
   always_comb begin
      c_write = cap_write;
      c_addr  = cap_addr;
      c_wdata = cap_wdata;
      if (state == IDLE) begin
         c_write = req_write;
         c_addr  = req_addr;
         c_wdata = req_wdata;
      end
      c_err  = (c_addr[2:0] != 3'd0) || (c_addr[63:3] >= 61'(DEPTH));
      c_idx  = c_addr[IDX_W+2:3];
      commit = (state != RESP) && (state_next == RESP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         count     <= 4'd0;
         cap_write <= 1'b0;
         cap_addr  <= 64'd0;
         cap_wdata <= 64'd0;
      end else begin
         state <= state_next;
         if (state == IDLE && req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            count     <= 4'(LATENCY - 1);
         end else if (state == WAIT && count != 4'd0) begin
            count <= count - 4'd1;
         end
      end
   end

   // Memory shares this block so reset blocks writes; memory itself is never cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_rdata <= 64'd0;
         resp_error <= 1'b0;
      end else if (commit) begin
         resp_error <= c_err;
         resp_rdata <= (c_write || c_err) ? 64'd0 : memory[c_idx];
         if (c_write && !c_err) begin
            memory[c_idx] <= c_wdata;
         end
      end else if (state == RESP && resp_ready) begin
         resp_rdata <= 64'd0;
         resp_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main function and a
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_error;

   logic        l1_reset;
   logic        l1_req_valid;
   logic        l1_req_ready;
   logic        l1_req_write;
   logic [63:0] l1_req_addr;
   logic [63:0] l1_req_wdata;
   logic        l1_resp_valid;
   logic        l1_resp_ready;
   logic [63:0] l1_resp_rdata;
   logic        l1_resp_error;

   int checkCount = 0;
   int errorCount = 0;

   localparam logic [63:0] PRE0 = 64'hAAAA_0000_AAAA_0000;
   localparam logic [63:0] PRE1 = 64'h0101_0101_0101_0101;
   localparam logic [63:0] PRE2 = 64'h5555_6666_7777_8888;
   localparam logic [63:0] PRE4 = 64'h1122_3344_5566_7788;
   localparam logic [63:0] STD  = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] L1V  = 64'h0BAD_F00D_1234_5678;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(128), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error)
   );

   dmem_responder #(.DEPTH(128), .LATENCY(1)) dut1 (
      .clk(clk), .reset(l1_reset),
      .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
      .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
      .resp_valid(l1_resp_valid), .resp_ready(l1_resp_ready),
      .resp_rdata(l1_resp_rdata), .resp_error(l1_resp_error)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
      end
   endtask

   // Presents one request, returns #1 after the edge on which resp_valid appears.
   task automatic applyStimulus(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                                output int lat);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
      req_wdata = 64'h0;
      checkOutput("busy_after_accept", {63'd0, req_ready}, 64'd0);
      lat = 21;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (resp_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic finishResponse(input string tag);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checkOutput({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
      checkOutput({tag, "_valid_drop"}, {63'd0, resp_valid}, 64'd0);
   endtask

   task automatic transaction(input string tag, input logic wr, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] expData, input logic expErr);
      int lat;
      applyStimulus(wr, addr, wdata, lat);
      checkOutput({tag, "_latency"}, 64'(lat), 64'd2);
      checkOutput({tag, "_rdata"}, resp_rdata, expData);
      checkOutput({tag, "_error"}, {63'd0, resp_error}, {63'd0, expErr});
      finishResponse(tag);
   endtask

   initial begin
      int lat;
      reset = 1'b1;  req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
      resp_ready = 1'b0;
      l1_reset = 1'b1; l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = 64'd0;
      l1_req_wdata = 64'd0; l1_resp_ready = 1'b0;
      dut.memory[0] = PRE0;
      dut.memory[1] = PRE1;
      dut.memory[2] = PRE2;
      dut.memory[4] = PRE4;
      dut1.memory[3] = L1V;

      #2;
      checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      checkOutput("rst_rdata", resp_rdata, 64'd0);
      checkOutput("rst_error", {63'd0, resp_error}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      transaction("load20", 1'b0, 64'h20, 64'h0, PRE4, 1'b0);
      transaction("store08", 1'b1, 64'h08, STD, 64'd0, 1'b0);
      checkOutput("mem1_after_store", dut.memory[1], STD);
      transaction("load08", 1'b0, 64'h08, 64'h0, STD, 1'b0);
      transaction("load0c_misalign", 1'b0, 64'h0C, 64'h0, 64'd0, 1'b1);
      transaction("store400_range", 1'b1, 64'h400, 64'h1234, 64'd0, 1'b1);
      checkOutput("mem0_unchanged", dut.memory[0], PRE0);
      transaction("store09_misalign", 1'b1, 64'h09, 64'h9999, 64'd0, 1'b1);
      checkOutput("mem1_unchanged", dut.memory[1], STD);

      // resp_ready held high before and during the wait must not shorten the latency
      resp_ready = 1'b1;
      transaction("early_ready", 1'b0, 64'h10, 64'h0, PRE2, 1'b0);

      // stall in RESP with a competing store presented on the request port
      applyStimulus(1'b0, 64'h20, 64'h0, lat);
      checkOutput("stall_latency", 64'(lat), 64'd2);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h7777;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         req_wdata = req_wdata + 64'd1;
         checkOutput("stall_valid", {63'd0, resp_valid}, 64'd1);
         checkOutput("stall_rdata", resp_rdata, PRE4);
         checkOutput("stall_req_ready", {63'd0, req_ready}, 64'd0);
      end
      req_valid = 1'b0;
      finishResponse("stall");
      checkOutput("stall_mem4", dut.memory[4], PRE4);

      // reset while a store waits
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hFEED;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkOutput("wait_rst_valid", {63'd0, resp_valid}, 64'd0);
      checkOutput("wait_rst_ready", {63'd0, req_ready}, 64'd1);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checkOutput("wait_rst_no_resp", {63'd0, resp_valid}, 64'd0);
      end
      checkOutput("wait_rst_mem2", dut.memory[2], PRE2);

      // reset while a response is held
      applyStimulus(1'b0, 64'h20, 64'h0, lat);
      checkOutput("resp_rst_latency", 64'(lat), 64'd2);
      #2 reset = 1'b1;
      #1;
      checkOutput("resp_rst_valid", {63'd0, resp_valid}, 64'd0);
      checkOutput("resp_rst_rdata", resp_rdata, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      transaction("first_after_rst", 1'b0, 64'h08, 64'h0, STD, 1'b0);

      // LATENCY=1 back-to-back loads with both valids held high
      l1_req_valid = 1'b1; l1_resp_ready = 1'b1; l1_req_addr = 64'h18;
      @(posedge clk); #1;
      l1_reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic expValid;
         @(posedge clk); #1;
         expValid = (i % 2 == 0);
         checkOutput("l1_valid", {63'd0, l1_resp_valid}, {63'd0, expValid});
         checkOutput("l1_ready", {63'd0, l1_req_ready}, {63'd0, !expValid});
         if (expValid) begin
            checkOutput("l1_rdata", l1_resp_rdata, L1V);
            checkOutput("l1_error", {63'd0, l1_resp_error}, 64'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
